// File: rtl/issue_pipe.sv
// issue_pipe: registered issue stage between the warp scheduler and operand collect.
// Each accepted packet gets reconvergence detection, issued-lane-mask formation and
// sync/exit flag decode. Packets pass through a 2-entry skid buffer (an output register
// plus a skid register). The block tracks exited warps and drops packets that arrive
// from them.
// Optional feature macro: ISSUE_PERF_CNT_EN adds per-warp issue counters and a stall counter.
module issue_pipe #(
  parameter int NUM_WARP_LOG = 3,
  parameter int SIZE_CORE    = 8,
  parameter int SIZE_PC      = 32,
  parameter int PACKET_W     = 128,
  parameter int PC_LSB       = 64,
  parameter int SYNC_BIT     = 120,
  parameter int EXIT_BIT     = 121
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    launch_i,
  input  logic                    sel_valid_i,
  output logic                    sel_ready_o,
  input  logic [NUM_WARP_LOG-1:0] sel_warp_i,
  input  logic [PACKET_W-1:0]     sel_packet_i,
  input  logic [SIZE_CORE-1:0]    active_mask_i,
  input  logic [SIZE_PC-1:0]      top_rpc_i,
  output logic                    iss_valid_o,
  input  logic                    iss_ready_i,
  output logic [NUM_WARP_LOG-1:0] iss_warp_o,
  output logic [PACKET_W-1:0]     iss_packet_o,
  output logic [SIZE_CORE-1:0]    iss_mask_o,
  output logic                    iss_sync_o,
  output logic                    iss_exit_o,
  output logic                    reconv_o,
  output logic [NUM_WARP_LOG-1:0] reconv_warp_o,
  output logic                    drop_o,
  output logic [2**NUM_WARP_LOG-1:0] exited_o
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [32*(2**NUM_WARP_LOG)-1:0] issue_cnt_o,
  output logic [31:0]                     stall_cnt_o
`endif
);

  localparam int NUM_WARP = 2**NUM_WARP_LOG;

  typedef struct packed {
    logic [NUM_WARP_LOG-1:0] warp;
    logic [PACKET_W-1:0]     packet;
    logic [SIZE_CORE-1:0]    mask;
    logic                    sync;
    logic                    isExit;
  } entry_t;

  entry_t                outReg, skidReg, newEntry;
  logic                  outValid, skidValid;
  logic [SIZE_PC-1:0]    curPc;
  logic                  hit, accept, isDrop, keep, drain;
  logic                  reconvQ, dropQ;
  logic [NUM_WARP_LOG-1:0] reconvWarpQ;
  logic [NUM_WARP-1:0]   exited;

  // Decode the incoming packet using values sampled in the accept cycle.
  // NOTE: every always_comb output is given a value up front, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    curPc           = sel_packet_i[PC_LSB +: SIZE_PC];
    hit             = (curPc == top_rpc_i);
    newEntry        = '0;
    newEntry.warp   = sel_warp_i;
    newEntry.packet = sel_packet_i;
    newEntry.mask   = hit ? '0 : active_mask_i;
    newEntry.sync   = sel_packet_i[SYNC_BIT];
    newEntry.isExit = sel_packet_i[EXIT_BIT];
  end

  // sel_ready_o comes straight from the skid flop, so it has no combinational path from iss_ready_i.
  assign sel_ready_o = ~skidValid;
  assign accept      = sel_valid_i & ~skidValid;
  assign isDrop      = exited[sel_warp_i];
  assign keep        = accept & ~isDrop;
  assign drain       = outValid & iss_ready_i;

  // Output/skid buffer: the output register refills from the skid first, then from a new packet.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
      outReg    <= '0;
      skidReg   <= '0;
    end else if (drain && skidValid) begin
      outReg    <= skidReg;
      skidValid <= 1'b0;
    end else if (drain || !outValid) begin
      outValid <= keep;
      if (keep) outReg <= newEntry;
    end else if (keep) begin
      skidValid <= 1'b1;
      skidReg   <= newEntry;
    end
  end

  // One-cycle reconvergence and drop pulses that follow an accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reconvQ     <= 1'b0;
      reconvWarpQ <= '0;
      dropQ       <= 1'b0;
    end else begin
      reconvQ <= keep & hit;
      dropQ   <= accept & isDrop;
      if (keep && hit) reconvWarpQ <= sel_warp_i;
    end
  end

  // Exited bitmap: a bit is set when an exit packet leaves the block, and launch clears the map with priority.
  always_ff @(posedge clk) begin
    if (!reset || launch_i) begin
      exited <= '0;
    end else if (drain && outReg.isExit) begin
      exited[outReg.warp] <= 1'b1;
    end
  end

  assign iss_valid_o   = outValid;
  assign iss_warp_o    = outReg.warp;
  assign iss_packet_o  = outReg.packet;
  assign iss_mask_o    = outReg.mask;
  assign iss_sync_o    = outReg.sync;
  assign iss_exit_o    = outReg.isExit;
  assign reconv_o      = reconvQ;
  assign reconv_warp_o = reconvWarpQ;
  assign drop_o        = dropQ;
  assign exited_o      = exited;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issueCnt [NUM_WARP];
  logic [31:0] stallCnt;

  // Wrapping per-warp issue counters and a stall-cycle counter, both cleared by launch.
  always_ff @(posedge clk) begin
    if (!reset || launch_i) begin
      for (int i = 0; i < NUM_WARP; i++) issueCnt[i] <= '0;
      stallCnt <= '0;
    end else begin
      if (drain) issueCnt[outReg.warp] <= issueCnt[outReg.warp] + 32'd1;
      if (outValid && !iss_ready_i) stallCnt <= stallCnt + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_WARP; g++) begin : g_cnt
    assign issue_cnt_o[32*g +: 32] = issueCnt[g];
  end
  assign stall_cnt_o = stallCnt;
`endif

endmodule

// File: tb/tb_issue_pipe.sv
// Scoreboard bench for issue_pipe. Expected issues are queued when a packet is accepted,
// then popped and compared as they leave through the output handshake.
module tb_issue_pipe;

  localparam int NW = 8;

  logic         clk = 1'b0;
  logic         reset, launch_i, sel_valid_i, sel_ready_o, iss_valid_o, iss_ready_i;
  logic [2:0]   sel_warp_i, iss_warp_o, reconv_warp_o;
  logic [127:0] sel_packet_i, iss_packet_o;
  logic [7:0]   active_mask_i, iss_mask_o;
  logic [31:0]  top_rpc_i;
  logic         iss_sync_o, iss_exit_o, reconv_o, drop_o;
  logic [NW-1:0] exited_o;
`ifdef ISSUE_PERF_CNT_EN
  logic [32*NW-1:0] issue_cnt_o;
  logic [31:0]      stall_cnt_o;
`endif

  issue_pipe dut (
    .clk(clk), .reset(reset), .launch_i(launch_i),
    .sel_valid_i(sel_valid_i), .sel_ready_o(sel_ready_o), .sel_warp_i(sel_warp_i),
    .sel_packet_i(sel_packet_i), .active_mask_i(active_mask_i), .top_rpc_i(top_rpc_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i), .iss_warp_o(iss_warp_o),
    .iss_packet_o(iss_packet_o), .iss_mask_o(iss_mask_o), .iss_sync_o(iss_sync_o),
    .iss_exit_o(iss_exit_o), .reconv_o(reconv_o), .reconv_warp_o(reconv_warp_o),
    .drop_o(drop_o), .exited_o(exited_o)
`ifdef ISSUE_PERF_CNT_EN
    , .issue_cnt_o(issue_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   warp;
    logic [127:0] packet;
    logic [7:0]   mask;
    logic         sync;
    logic         ex;
  } item_t;

  item_t        sb[$];
  int           tests = 0;
  int           fails = 0;
  int           reconvCount = 0;
  int           dropCount = 0;
  logic [NW-1:0] modelExited = '0;

  function automatic logic [127:0] mkPacket(input logic [31:0] pc, input logic s, input logic e);
    logic [127:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    p[64 +: 32] = pc;
    p[120] = s;
    p[121] = e;
    return p;
  endfunction

  // Monitor: scoreboard pops, stall stability and exited-bitmap model, all sampled on the falling edge.
  logic         prevStall = 1'b0;
  item_t        prevOut;
  always @(negedge clk) begin
    item_t act, exp;
    act = {iss_warp_o, iss_packet_o, iss_mask_o, iss_sync_o, iss_exit_o};
    if (!reset) begin
      sb.delete();
      modelExited <= '0;
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        tests++;
        if (iss_valid_o !== 1'b1 || act !== prevOut) begin
          fails++;
          $display("FAIL stall_stable: got valid=%b %h, required valid=1 %h", iss_valid_o, act, prevOut);
        end
      end
      if (iss_valid_o && iss_ready_i) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_issue: got warp=%0d with empty scoreboard", iss_warp_o);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            fails++;
            $display("FAIL issue_data: got warp=%0d mask=%h sync=%b exit=%b pkt=%h, required warp=%0d mask=%h sync=%b exit=%b pkt=%h",
                     act.warp, act.mask, act.sync, act.ex, act.packet, exp.warp, exp.mask, exp.sync, exp.ex, exp.packet);
          end
        end
        if (iss_exit_o) modelExited[iss_warp_o] <= 1'b1;
      end
      if (launch_i) modelExited <= '0;
      tests++;
      if (exited_o !== modelExited) begin
        fails++;
        $display("FAIL exited_map: got %b, required %b", exited_o, modelExited);
      end
      if (reconv_o) reconvCount++;
      if (drop_o) dropCount++;
      prevStall = iss_valid_o && !iss_ready_i;
      prevOut   = act;
    end
  end

  // Drive one packet and hold it until accepted. Returns 1 ns after the accepting edge.
  task automatic send(input logic [2:0] w, input logic [31:0] pc, input logic [31:0] rpc,
                      input logic [7:0] m, input logic s, input logic e);
    logic [127:0] p;
    bit done = 0;
    p = mkPacket(pc, s, e);
    sel_valid_i = 1'b1; sel_warp_i = w; sel_packet_i = p; active_mask_i = m; top_rpc_i = rpc;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (sel_ready_o) begin
        done = 1;
        if (!modelExited[w]) sb.push_back({w, p, (pc == rpc) ? 8'h00 : m, s, e});
      end
      @(posedge clk); #1;
    end
    sel_valid_i = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL accept_timeout: got no accept for warp %0d, required accept within 20 cycles", w);
    end
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic pulseLaunch();
    launch_i = 1'b1;
    @(posedge clk); #1;
    launch_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; launch_i = 1'b0; sel_valid_i = 1'b0; sel_warp_i = '0; sel_packet_i = '0;
    active_mask_i = '0; top_rpc_i = '0; iss_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (iss_valid_o !== 1'b0 || sel_ready_o !== 1'b1 || reconv_o !== 1'b0 || drop_o !== 1'b0 ||
        exited_o !== '0 || iss_packet_o !== '0 || iss_mask_o !== '0 || iss_warp_o !== '0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b ready=%b reconv=%b drop=%b exited=%b mask=%h, required 0 1 0 0 0 0",
               iss_valid_o, sel_ready_o, reconv_o, drop_o, exited_o, iss_mask_o);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_throughput();
    int r0;
    logic [127:0] p;
    r0 = reconvCount;
    iss_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = mkPacket(32'h100, 1'b0, 1'b0);
      sel_valid_i = 1'b1; sel_warp_i = 3'(i); sel_packet_i = p; active_mask_i = 8'hFF; top_rpc_i = 32'h200;
      @(negedge clk);
      tests++;
      if (sel_ready_o !== 1'b1) begin
        fails++;
        $display("FAIL thr_ready: got %b at warp %0d, required 1", sel_ready_o, i);
      end
      sb.push_back({3'(i), p, 8'hFF, 1'b0, 1'b0});
      @(posedge clk); #1;
      tests++;
      if (iss_valid_o !== 1'b1 || iss_warp_o !== 3'(i) || iss_mask_o !== 8'hFF) begin
        fails++;
        $display("FAIL thr_latency: got valid=%b warp=%0d mask=%h, required 1 %0d ff", iss_valid_o, iss_warp_o, iss_mask_o, i);
      end
    end
    sel_valid_i = 1'b0;
    waitDrain();
    tests++;
    if (reconvCount != r0) begin
      fails++;
      $display("FAIL thr_no_reconv: got %0d pulses, required 0", reconvCount - r0);
    end
  endtask

  task automatic test_reconv();
    iss_ready_i = 1'b1;
    send(3'd2, 32'h40, 32'h40, 8'h0F, 1'b0, 1'b0);
    tests++;
    if (reconv_o !== 1'b1 || reconv_warp_o !== 3'd2 || iss_valid_o !== 1'b1 || iss_mask_o !== 8'h00) begin
      fails++;
      $display("FAIL reconv_pulse: got reconv=%b warp=%0d valid=%b mask=%h, required 1 2 1 00",
               reconv_o, reconv_warp_o, iss_valid_o, iss_mask_o);
    end
    @(posedge clk); #1;
    tests++;
    if (reconv_o !== 1'b0) begin
      fails++;
      $display("FAIL reconv_one_cycle: got %b, required 0", reconv_o);
    end
    // Only the top PC bit differs: a full-width compare must not reconverge.
    send(3'd3, 32'h40, 32'h8000_0040, 8'h0F, 1'b0, 1'b0);
    tests++;
    if (reconv_o !== 1'b0 || iss_mask_o !== 8'h0F) begin
      fails++;
      $display("FAIL reconv_msb: got reconv=%b mask=%h, required 0 0f", reconv_o, iss_mask_o);
    end
    waitDrain();
  endtask

  task automatic test_backpressure();
    iss_ready_i = 1'b0;
    send(3'd1, 32'h10, 32'h0, 8'hA1, 1'b0, 1'b0);
    send(3'd2, 32'h20, 32'h0, 8'hB2, 1'b0, 1'b0);
    sel_valid_i = 1'b1; sel_warp_i = 3'd3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if (sel_ready_o !== 1'b0 || iss_valid_o !== 1'b1 || iss_warp_o !== 3'd1) begin
        fails++;
        $display("FAIL bp_full: got ready=%b valid=%b warp=%0d, required 0 1 1", sel_ready_o, iss_valid_o, iss_warp_o);
      end
    end
    @(posedge clk); #1;
    iss_ready_i = 1'b1;
    send(3'd3, 32'h30, 32'h0, 8'hC3, 1'b0, 1'b0);
    waitDrain();
  endtask

  task automatic test_exit_drop();
    int d0;
    iss_ready_i = 1'b1;
    send(3'd5, 32'h300, 32'h0, 8'hAA, 1'b0, 1'b1);
    @(posedge clk); #1;
    tests++;
    if (exited_o[5] !== 1'b1) begin
      fails++;
      $display("FAIL exit_set: got exited=%b, required bit5=1", exited_o);
    end
    d0 = dropCount;
    send(3'd5, 32'h304, 32'h0, 8'h55, 1'b0, 1'b0);
    tests++;
    if (drop_o !== 1'b1 || iss_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL drop_pulse: got drop=%b valid=%b, required 1 0", drop_o, iss_valid_o);
    end
    @(posedge clk); #1;
    tests++;
    if (drop_o !== 1'b0 || dropCount != d0 + 1) begin
      fails++;
      $display("FAIL drop_one_cycle: got drop=%b pulses=%0d, required 0 1", drop_o, dropCount - d0);
    end
    send(3'd4, 32'h10, 32'h20, 8'h33, 1'b1, 1'b0);
    waitDrain();
    pulseLaunch();
    tests++;
    if (exited_o !== '0) begin
      fails++;
      $display("FAIL launch_clear: got %b, required 0", exited_o);
    end
    // Launch coinciding with an exit handshake: launch wins.
    iss_ready_i = 1'b0;
    send(3'd3, 32'h500, 32'h0, 8'h01, 1'b0, 1'b1);
    iss_ready_i = 1'b1; launch_i = 1'b1;
    @(posedge clk); #1;
    launch_i = 1'b0;
    tests++;
    if (exited_o !== '0 || iss_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL launch_vs_exit: got exited=%b valid=%b, required 0 0", exited_o, iss_valid_o);
    end
    waitDrain();
  endtask

  task automatic test_reset_mid();
    iss_ready_i = 1'b1;
    send(3'd6, 32'h600, 32'h0, 8'hF0, 1'b0, 1'b1);
    @(posedge clk); #1;
    iss_ready_i = 1'b0;
    send(3'd1, 32'h610, 32'h0, 8'h11, 1'b0, 1'b0);
    send(3'd2, 32'h620, 32'h0, 8'h22, 1'b0, 1'b0);
    tests++;
    if (iss_valid_o !== 1'b1 || sel_ready_o !== 1'b0 || exited_o[6] !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: got valid=%b ready=%b exited=%b, required 1 0 bit6=1", iss_valid_o, sel_ready_o, exited_o);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tests++;
    if (iss_valid_o !== 1'b0 || sel_ready_o !== 1'b1 || exited_o !== '0 || reconv_o !== 1'b0 || drop_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: got valid=%b ready=%b exited=%b reconv=%b drop=%b, required 0 1 0 0 0",
               iss_valid_o, sel_ready_o, exited_o, reconv_o, drop_o);
    end
    iss_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(3'd6, 32'h630, 32'h0, 8'h66, 1'b0, 1'b0);
    waitDrain();
  endtask

`ifdef ISSUE_PERF_CNT_EN
  task automatic test_perf_cnt();
    iss_ready_i = 1'b1;
    pulseLaunch();
    iss_ready_i = 1'b0;
    send(3'd1, 32'h700, 32'h0, 8'h01, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    iss_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send(3'd1, 32'h704 + 32'(i), 32'h0, 8'h01, 1'b0, 1'b0);
    waitDrain();
    tests++;
    if (issue_cnt_o[32 +: 32] !== 32'd4 || stall_cnt_o !== 32'd2 || issue_cnt_o[0 +: 32] !== 32'd0) begin
      fails++;
      $display("FAIL perf_cnt: got w1=%0d stall=%0d w0=%0d, required 4 2 0",
               issue_cnt_o[32 +: 32], stall_cnt_o, issue_cnt_o[0 +: 32]);
    end
    pulseLaunch();
    tests++;
    if (issue_cnt_o !== '0 || stall_cnt_o !== 32'd0) begin
      fails++;
      $display("FAIL perf_clear: got w1=%0d stall=%0d, required 0 0", issue_cnt_o[32 +: 32], stall_cnt_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_throughput();
    test_reconv();
    test_backpressure();
    test_exit_drop();
    test_reset_mid();
`ifdef ISSUE_PERF_CNT_EN
    test_perf_cnt();
`endif
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_pipe.md
Name: issue_pipe

Overview:
- Parametrised, registered successor to the combinational issue stage.
- Accepts one selected packet per cycle from the warp scheduler through a valid/ready handshake.
- Per packet: detects reconvergence against the warp's top reconvergence PC, forms the issued lane mask, and decodes sync/exit flags.
- Tracks exited warps, drops their stray packets, and buffers through a 2-entry skid (output register + skid register) toward operand collect.

Parameters:
- NUM_WARP_LOG, 3, log2 of warp count; NUM_WARP = 2**NUM_WARP_LOG.
- SIZE_CORE, 8, lanes per warp (mask width).
- SIZE_PC, 32, PC width.
- PACKET_W, 128, decoded packet width.
- PC_LSB, 64, bit offset of the current-PC field [PC_LSB+SIZE_PC-1:PC_LSB] within the packet.
- SYNC_BIT, 120, packet bit flagging a sync instruction.
- EXIT_BIT, 121, packet bit flagging an exit instruction.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- launch_i  in  1  kernel launch; clears the exited bitmap.
- sel_valid_i  in  1  scheduler packet valid.
- sel_ready_o  out  1  issue_pipe can accept.
- sel_warp_i  in  NUM_WARP_LOG  warp id.
- sel_packet_i  in  PACKET_W  decoded packet.
- active_mask_i  in  SIZE_CORE  warp's active mask (top of SIMT stack).
- top_rpc_i  in  SIZE_PC  warp's top reconvergence PC.
- iss_valid_o  out  1  issued packet valid.
- iss_ready_i  in  1  downstream accepts.
- iss_warp_o  out  NUM_WARP_LOG  issued warp id.
- iss_packet_o  out  PACKET_W  issued packet.
- iss_mask_o  out  SIZE_CORE  issued lane mask.
- iss_sync_o  out  1  issued packet is sync.
- iss_exit_o  out  1  issued packet is exit.
- reconv_o  out  1  one-cycle reconvergence pulse.
- reconv_warp_o  out  NUM_WARP_LOG  warp reconverging.
- drop_o  out  1  one-cycle pulse: packet from exited warp discarded.
- exited_o  out  NUM_WARP  exited-warp bitmap.

Behaviour:
- Reset (reset==0 at posedge): iss_valid_o=0, skid empty, sel_ready_o=1, reconv_o=0, drop_o=0, exited_o=0; data outputs 0. A mid-operation reset discards the output and skid contents; nothing in flight is reported.
- Accept when sel_valid_i & sel_ready_o. All processing uses values sampled at accept: sel_packet_i, active_mask_i, top_rpc_i.
- Processing per accepted packet:
  - cur_pc = sel_packet_i[PC_LSB+SIZE_PC-1:PC_LSB].
  - hit = (cur_pc == top_rpc_i), full SIZE_PC-bit compare.
  - mask = hit ? 0 : active_mask_i.
  - sync = packet[SYNC_BIT]; exit = packet[EXIT_BIT].
- Drop: if exited_o[sel_warp_i] is set at accept, the packet is accepted but discarded. drop_o pulses the next cycle; no issue and no reconv.
- Reconvergence: on a non-dropped accept with hit, reconv_o=1 and reconv_warp_o=warp the next cycle, for exactly one cycle. The packet is still issued, with mask 0.
- Exit: exited_o[warp] is set on the cycle the exit packet handshakes out (iss_valid_o & iss_ready_i & iss_exit_o), not at accept.
- Latency: 1 cycle, accept to iss_valid_o, when the output register is free.
- Buffering:
  - Output register holds the issued packet. The skid register holds one more.
  - sel_ready_o = skid empty; registered, no combinational path from iss_ready_i.
  - Output free or draining this cycle: new packet goes to the output register.
  - Output full and stalled: new packet goes to the skid register.
  - On drain with skid full: skid moves to output; the skid frees the next cycle.
- Ordering: strict FIFO. Outputs stay stable while iss_valid_o & !iss_ready_i.
- Simultaneous events:
  - launch_i and an exit handshake in the same cycle: launch wins, bitmap cleared.
  - launch_i does not flush buffered packets.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- Defined:
  - Adds output issue_cnt_o[32*NUM_WARP-1:0], one 32-bit wrapping counter per warp, incremented on each output handshake.
  - Adds output stall_cnt_o[31:0], incremented each cycle iss_valid_o & !iss_ready_i.
  - Counters reset to 0 and are cleared by launch_i.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Throughput: iss_ready_i=1, warps 0..7 back-to-back, cur_pc=0x100, top_rpc=0x200, mask=0xFF -> eight issues at 1-cycle latency, each mask=0xFF, reconv_o never set, sel_ready_o constantly 1.
- Reconvergence: warp 2, cur_pc=0x40, top_rpc=0x40, mask=0x0F -> next cycle iss_mask_o=0x00, reconv_o=1 with reconv_warp_o=2 for one cycle.
- Backpressure: iss_ready_i=0 for 3 cycles while sending A,B,C -> A in output, B in skid, sel_ready_o=0, C held by scheduler; after release, order A,B,C with no loss or duplication.
- Exit/drop: warp 5 exit packet drained, then another warp 5 packet -> exited_o[5]=1, drop_o pulses, no issue; then launch_i=1 -> exited_o=0.
- Reset mid-stall: output and skid full, reset=0 for one cycle -> iss_valid_o=0, sel_ready_o=1, exited_o=0 next cycle.
- ISSUE_PERF_CNT_EN: 4 issues on warp 1 with 2 stall cycles -> issue_cnt for warp 1 = 4, stall_cnt_o=2; launch_i clears both.
